// File: rtl/keypad_player_if.sv
// -----------------------------------------------------------------------------
// keypad_player_if
//   Key-offer handshake between a key source and keypad_player.
//
//   key_idx   : key matrix position (pb bit index 0..15)
//   key_valid : key_idx is offered this cycle
//   key_ready : keypad_player accepts key_idx this cycle
//
//   master : key source (drives key_idx / key_valid)
//   slave  : keypad_player (drives key_ready)
// -----------------------------------------------------------------------------
interface keypad_player_if;
  logic [3:0] key_idx;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_idx, output key_valid, input key_ready);
  modport slave  (input key_idx, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_player.sv
// -----------------------------------------------------------------------------
// keypad_player
//   Plays a sequence of key presses onto active-low push-button lines. Each
//   accepted key is held low for HOLD_CYCLES clocks, followed by a release gap
//   of GAP_CYCLES clocks, after which key_done pulses and keys_sent counts up.
//
//   Build option: define KEYPAD_PLAYER_FIFO_EN to queue up to FIFO_DEPTH keys.
//   Without it, a single holding register accepts one key at a time and only
//   while the player is idle.
//
// Ports
//   clock_50m : board clock
//   rst       : synchronous active-high reset
//   key_if    : key offer handshake (slave modport: key_idx, key_valid in,
//               key_ready out)
//   pb        : active-low push-button lines, 1 = released (registered)
//   busy      : press or gap in progress, or a key is pending
//   key_done  : one-cycle pulse at the end of each key's gap
//   keys_sent : count of completed keys, wraps 255 -> 0
// -----------------------------------------------------------------------------
module keypad_player #(
  parameter logic [23:0] HOLD_CYCLES = 24'd4194304,
  parameter logic [23:0] GAP_CYCLES  = 24'd4194304,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                 clock_50m,
  input  logic                 rst,
  keypad_player_if.slave       key_if,
  output logic [15:0]          pb,
  output logic                 busy,
  output logic                 key_done,
  output logic [7:0]           keys_sent
);

  // A zero duration still occupies one cycle.
  localparam logic [23:0] HOLD_EFF = (HOLD_CYCLES == 24'd0) ? 24'd1 : HOLD_CYCLES;
  localparam logic [23:0] GAP_EFF  = (GAP_CYCLES  == 24'd0) ? 24'd1 : GAP_CYCLES;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("keypad_player: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] pb_q, pb_d;
  logic        key_done_q, key_done_d;
  logic [7:0]  keys_sent_q, keys_sent_d;
  logic        avail_q;     // queue was non-empty last cycle
  logic        ready_en_q;  // low on reset edges, high from the first edge out of reset

  logic        push, pop, q_empty;
  logic [3:0]  head_key;

  assign push = key_if.key_valid && key_if.key_ready;

  // ---------------------------------------------------------------------------
  // Key storage
  // ---------------------------------------------------------------------------
`ifdef KEYPAD_PLAYER_FIFO_EN
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          q_full;

  assign q_empty  = (count_q == '0);
  assign q_full   = (count_q == CW'(FIFO_DEPTH));
  assign head_key = mem_q[rd_ptr_q];
  assign key_if.key_ready = ready_en_q && !rst && !q_full;

  // NOTE: storage array has no reset; count_q alone decides which entries are live.
  always_ff @(posedge clock_50m) begin
    if (push) mem_q[wr_ptr_q] <= key_if.key_idx;
  end

  // Pointers wrap naturally at FIFO_DEPTH since it is a power of two.
  always_ff @(posedge clock_50m) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;   // idle, or push and pop cancel out
      endcase
    end
  end
`else
  logic [3:0] hold_key_q;
  logic       hold_valid_q;

  assign q_empty  = !hold_valid_q;
  assign head_key = hold_key_q;
  assign key_if.key_ready = ready_en_q && !rst && (state_q == IDLE) && !hold_valid_q;

  always_ff @(posedge clock_50m) begin
    if (rst) begin
      hold_key_q   <= '0;
      hold_valid_q <= 1'b0;
    end else if (push) begin
      hold_key_q   <= key_if.key_idx;
      hold_valid_q <= 1'b1;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Player FSM
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clock_50m) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pb_q        <= 16'hFFFF;
      key_done_q  <= 1'b0;
      keys_sent_q <= '0;
      avail_q     <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pb_q        <= pb_d;
      key_done_q  <= key_done_d;
      keys_sent_q <= keys_sent_d;
      avail_q     <= !q_empty;
      ready_en_q  <= 1'b1;
    end
  end

  // From IDLE, launch waits for the registered avail_q, so a freshly accepted
  // key reaches pb two edges after acceptance. From GAP the next key launches
  // immediately, giving back-to-back presses with no IDLE cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pb_d        = pb_q;
    key_done_d  = 1'b0;
    keys_sent_d = keys_sent_q;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (avail_q && !q_empty) begin
          pop     = 1'b1;
          state_d = PRESS;
          cnt_d   = '0;
          pb_d    = ~(16'h0001 << head_key);
        end
      end
      PRESS: begin
        if (cnt_q == HOLD_EFF - 24'd1) begin
          state_d = GAP;
          cnt_d   = '0;
          pb_d    = 16'hFFFF;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_EFF - 24'd1) begin
          key_done_d  = 1'b1;
          keys_sent_d = keys_sent_q + 8'd1;
          cnt_d       = '0;
          if (!q_empty) begin
            pop     = 1'b1;
            state_d = PRESS;
            pb_d    = ~(16'h0001 << head_key);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: begin
        state_d = IDLE;
        pb_d    = 16'hFFFF;
      end
    endcase
  end

  assign pb        = pb_q;
  assign key_done  = key_done_q;
  assign keys_sent = keys_sent_q;
  assign busy      = (state_q != IDLE) || !q_empty;

endmodule

// File: tb/tb_keypad_player.sv
// -----------------------------------------------------------------------------
// tb_keypad_player
//   Directed bench for keypad_player with HOLD_CYCLES = 4, GAP_CYCLES = 3.
//   Edge N is the accept edge; values are observed 1 time unit after each
//   rising edge, so "edge N+k" means the value registered on that edge.
// -----------------------------------------------------------------------------
module tb_keypad_player;

  logic        clock_50m = 1'b0;
  logic        rst;
  logic [15:0] pb;
  logic        busy;
  logic        key_done;
  logic [7:0]  keys_sent;

  int checks   = 0;
  int failures = 0;
  int exp_sent = 0;

  // press monitor state used by test_full
  logic [15:0] prev_pb = 16'hFFFF;
  int          mon_dones = 0;
  int          pressed[$];

  keypad_player_if kif ();

  keypad_player #(
    .HOLD_CYCLES(24'd4),
    .GAP_CYCLES (24'd3),
    .FIFO_DEPTH (8)
  ) dut (
    .clock_50m(clock_50m),
    .rst      (rst),
    .key_if   (kif),
    .pb       (pb),
    .busy     (busy),
    .key_done (key_done),
    .keys_sent(keys_sent)
  );

  always #10 clock_50m = ~clock_50m;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock_50m);
    #1;
  endtask

  function automatic logic [15:0] mask(input int b);
    return ~(16'h0001 << b);
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_idx   = 4'd0;
    tick();
    tick();
    checks++; if (pb !== 16'hFFFF) begin failures++; $display("FAIL reset_pb: got %h expected ffff", pb); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (key_done !== 1'b0) begin failures++; $display("FAIL reset_key_done: got %b expected 0", key_done); end
    checks++; if (keys_sent !== 8'd0) begin failures++; $display("FAIL reset_keys_sent: got %0d expected 0", keys_sent); end
    checks++; if (kif.key_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_rst: got %b expected 0", kif.key_ready); end
    rst = 1'b0;
    #1;
    checks++; if (kif.key_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_before_edge: got %b expected 0", kif.key_ready); end
    tick();
    checks++; if (kif.key_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after_edge: got %b expected 1", kif.key_ready); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_key();
    logic [15:0] exp_pb;
    logic        exp_done, exp_busy;
    kif.key_idx   = 4'd5;
    kif.key_valid = 1'b1;
    #1;
    checks++; if (kif.key_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b expected 1", kif.key_ready); end
    tick();                       // edge N
    kif.key_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      exp_pb   = (k >= 2 && k <= 5) ? 16'hFFDF : 16'hFFFF;
      exp_done = (k == 9);
      exp_busy = (k <= 8);
      checks++; if (pb !== exp_pb) begin failures++; $display("FAIL single_pb N+%0d: got %h expected %h", k, pb, exp_pb); end
      checks++; if (key_done !== exp_done) begin failures++; $display("FAIL single_done N+%0d: got %b expected %b", k, key_done, exp_done); end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL single_busy N+%0d: got %b expected %b", k, busy, exp_busy); end
    end
    exp_sent = (exp_sent + 1) % 256;
    checks++; if (keys_sent !== 8'(exp_sent)) begin failures++; $display("FAIL single_keys_sent: got %0d expected %0d", keys_sent, exp_sent); end
  endtask

`ifdef KEYPAD_PLAYER_FIFO_EN
  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int          keys[3] = '{0, 13, 15};
    logic [15:0] exp_pb;
    logic        exp_done, exp_busy;
    int          idx, j;
    for (int k = 0; k < 26; k++) begin
      if (k < 3) begin
        kif.key_idx   = 4'(keys[k]);
        kif.key_valid = 1'b1;
      end else begin
        kif.key_valid = 1'b0;
      end
      tick();                     // edge N+k
      exp_pb = 16'hFFFF;
      if (k >= 2) begin
        idx = (k - 2) / 7;
        j   = (k - 2) % 7;
        if (idx < 3 && j < 4) exp_pb = mask(keys[idx]);
      end
      exp_done = (k == 9) || (k == 16) || (k == 23);
      exp_busy = (k <= 22);
      checks++; if (pb !== exp_pb) begin failures++; $display("FAIL b2b_pb N+%0d: got %h expected %h", k, pb, exp_pb); end
      checks++; if (key_done !== exp_done) begin failures++; $display("FAIL b2b_done N+%0d: got %b expected %b", k, key_done, exp_done); end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL b2b_busy N+%0d: got %b expected %b", k, busy, exp_busy); end
    end
    exp_sent = (exp_sent + 3) % 256;
    checks++; if (keys_sent !== 8'(exp_sent)) begin failures++; $display("FAIL b2b_keys_sent: got %0d expected %0d", keys_sent, exp_sent); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic observe_pb();
    checks++;
    if ($countones(~pb) > 1) begin failures++; $display("FAIL full_one_hot: pb %h has more than one low bit", pb); end
    if (pb !== 16'hFFFF && prev_pb === 16'hFFFF)
      for (int b = 0; b < 16; b++) if (pb[b] == 1'b0) pressed.push_back(b);
    if (key_done === 1'b1) mon_dones++;
    prev_pb = pb;
  endtask

  task automatic test_full();
    logic exp_rdy;
    int   c;
    pressed.delete();
    mon_dones = 0;
    prev_pb   = pb;
    for (int p = 0; p < 10; p++) begin
      kif.key_idx   = 4'(p);
      kif.key_valid = 1'b1;
      #1;
      exp_rdy = (p <= 8);
      checks++; if (kif.key_ready !== exp_rdy) begin failures++; $display("FAIL full_ready push %0d: got %b expected %b", p, kif.key_ready, exp_rdy); end
      tick();
      observe_pb();
    end
    kif.key_valid = 1'b0;
    c = 0;
    while (busy === 1'b1 && c < 200) begin
      tick();
      observe_pb();
      c++;
    end
    tick();
    observe_pb();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_drain_timeout: busy %b expected 0", busy); end
    checks++; if (pressed.size() != 9) begin failures++; $display("FAIL full_press_count: got %0d expected 9", pressed.size()); end
    for (int i = 0; i < pressed.size() && i < 10; i++) begin
      checks++; if (pressed[i] != i) begin failures++; $display("FAIL full_press_order %0d: got key %0d expected %0d", i, pressed[i], i); end
    end
    checks++; if (mon_dones != 9) begin failures++; $display("FAIL full_done_count: got %0d expected 9", mon_dones); end
    exp_sent = (exp_sent + 9) % 256;
    checks++; if (keys_sent !== 8'(exp_sent)) begin failures++; $display("FAIL full_keys_sent: got %0d expected %0d", keys_sent, exp_sent); end
  endtask
`else
  // ---------------------------------------------------------------------------
  task automatic test_no_fifo_ignore();
    logic [15:0] exp_pb;
    logic        exp_rdy, exp_done;
    kif.key_idx   = 4'd3;
    kif.key_valid = 1'b1;
    #1;
    checks++; if (kif.key_ready !== 1'b1) begin failures++; $display("FAIL nofifo_ready_pre: got %b expected 1", kif.key_ready); end
    tick();                       // edge N
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick();
      exp_rdy  = (k >= 9);
      exp_pb   = (k >= 2 && k <= 5) ? 16'hFFF7 : 16'hFFFF;
      exp_done = (k == 9);
      checks++; if (kif.key_ready !== exp_rdy) begin failures++; $display("FAIL nofifo_ready N+%0d: got %b expected %b", k, kif.key_ready, exp_rdy); end
      checks++; if (pb !== exp_pb) begin failures++; $display("FAIL nofifo_pb N+%0d: got %h expected %h", k, pb, exp_pb); end
      checks++; if (key_done !== exp_done) begin failures++; $display("FAIL nofifo_done N+%0d: got %b expected %b", k, key_done, exp_done); end
      // offer key 9 at edges N+1..N+8 while the block is not ready
      kif.key_idx   = 4'd9;
      kif.key_valid = (k + 1 <= 8);
    end
    kif.key_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nofifo_busy_end: got %b expected 0", busy); end
    exp_sent = (exp_sent + 1) % 256;
    checks++; if (keys_sent !== 8'(exp_sent)) begin failures++; $display("FAIL nofifo_keys_sent: got %0d expected %0d", keys_sent, exp_sent); end
  endtask
`endif

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_press();
    kif.key_idx   = 4'd15;
    kif.key_valid = 1'b1;
    tick();                       // edge N: accept 15
`ifdef KEYPAD_PLAYER_FIFO_EN
    kif.key_idx   = 4'd4;         // queue a second key that reset must discard
`else
    kif.key_valid = 1'b0;
`endif
    tick();                       // edge N+1
    kif.key_valid = 1'b0;
    tick();                       // edge N+2: first press cycle
    checks++; if (pb !== 16'h7FFF) begin failures++; $display("FAIL rmid_pressed: got %h expected 7fff", pb); end
    rst = 1'b1;
    tick();                       // edge N+3: second press cycle, reset applies
    checks++; if (pb !== 16'hFFFF) begin failures++; $display("FAIL rmid_pb: got %h expected ffff", pb); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (key_done !== 1'b0) begin failures++; $display("FAIL rmid_done: got %b expected 0", key_done); end
    checks++; if (keys_sent !== 8'd0) begin failures++; $display("FAIL rmid_keys_sent: got %0d expected 0", keys_sent); end
    checks++; if (kif.key_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready: got %b expected 0", kif.key_ready); end
    rst = 1'b0;
    exp_sent = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++; if (pb !== 16'hFFFF || key_done !== 1'b0) begin failures++; $display("FAIL rmid_after %0d: pb %h done %b expected ffff 0", k, pb, key_done); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_queue_empty: busy %b expected 0", busy); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    int   accepted = 0;
    int   dones    = 0;
    int   cyc      = 0;
    logic rdy;
    while (dones < 256 && cyc < 4000) begin
      kif.key_valid = (accepted < 256);
      kif.key_idx   = 4'(accepted % 16);
      #1;
      rdy = kif.key_ready;
      tick();
      cyc++;
      if (rdy && kif.key_valid) accepted++;
      if (key_done === 1'b1) begin
        dones++;
        if (dones == 255) begin
          checks++; if (keys_sent !== 8'd255) begin failures++; $display("FAIL wrap_at_255: got %0d expected 255", keys_sent); end
        end
      end
    end
    kif.key_valid = 1'b0;
    checks++; if (dones != 256) begin failures++; $display("FAIL wrap_done_count: got %0d expected 256 (cycles %0d)", dones, cyc); end
    checks++; if (accepted != 256) begin failures++; $display("FAIL wrap_accepted: got %0d expected 256", accepted); end
    checks++; if (keys_sent !== 8'd0) begin failures++; $display("FAIL wrap_keys_sent: got %0d expected 0", keys_sent); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_busy_end: got %b expected 0", busy); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst           = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_idx   = 4'd0;
    test_reset();
    test_single_key();
`ifdef KEYPAD_PLAYER_FIFO_EN
    test_back_to_back();
    test_full();
`else
    test_no_fifo_ignore();
`endif
    test_reset_mid_press();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_player.md
KEYPAD_PLAYER -- requirements
Module: keypad_player

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset: clock_50m and rst, both sampled on the rising edge of clock_50m.
REQ-002 Parameter HOLD_CYCLES SHALL be 24 bits wide with default 4194304, giving the key-down duration in clock_50m cycles.
REQ-003 Parameter GAP_CYCLES SHALL be 24 bits wide with default 4194304, giving the key-up duration after each press.
REQ-004 Parameter FIFO_DEPTH SHALL default to 8 and be a power of two (only used when KEYPAD_PLAYER_FIFO_EN is defined).
REQ-005 clock_50m  input  1  board clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 key_idx  input  4  key matrix position to press; pb bit index 0..15.
REQ-008 key_valid  input  1  key_idx offered this cycle.
REQ-009 key_ready  output  1  block accepts key_idx this cycle.
REQ-010 pb  output  16  active-low push-button lines for keypad_driver; 1 = released.
REQ-011 busy  output  1  a press or gap is in progress, or keys are queued.
REQ-012 key_done  output  1  one-cycle pulse at the end of each key's gap.
REQ-013 keys_sent  output  8  count of completed keys.

Function
REQ-014 A key SHALL be accepted on any rising edge where key_valid and key_ready are both 1; key_idx is captured on that edge.
REQ-015 The FSM SHALL have exactly three states: IDLE, PRESS and GAP.
REQ-016 In IDLE with a key pending, the FSM SHALL pop the key on the next edge and enter PRESS.
- pb[key_idx] is 0 and all other pb bits are 1 from that edge on.
- Latency is 2 edges from the accept edge when the block was idle.
REQ-017 PRESS SHALL last exactly HOLD_CYCLES cycles and then enter GAP with pb = 16'hFFFF.
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles, then pulse key_done for one cycle and increment keys_sent.
- Next state is PRESS with the next queued key when one is pending (no IDLE cycle in between).
- Otherwise next state is IDLE.
REQ-019 A HOLD_CYCLES or GAP_CYCLES value of 0 SHALL be treated as 1.
REQ-020 At most one pb bit SHALL be 0 in any cycle.
REQ-021 pb SHALL be driven directly from a register, with no combinational path from any input.
REQ-022 keys_sent SHALL wrap from 255 to 0.
REQ-023 busy SHALL be 1 whenever the state is not IDLE or a key is pending; busy is 0 only in IDLE with nothing pending.
REQ-024 key_valid while key_ready is 0 SHALL be ignored; no key is captured and no error is flagged.
REQ-025 A simultaneous accept and pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.

Reset
REQ-026 When rst is 1 on an edge, the following SHALL take effect on that same edge:
- pb = 16'hFFFF, state = IDLE, key_done = 0, busy = 0, keys_sent = 0.
- All queued keys are discarded and the counters are cleared.
REQ-027 Reset asserted mid-press SHALL release the key on that edge; no key_done pulse is produced for the aborted key.
REQ-028 key_ready SHALL be 0 while rst is 1 and become 1 on the first edge with rst = 0.

Configuration
REQ-029 Macro KEYPAD_PLAYER_FIFO_EN SHALL control key queuing.
- Defined: keys are held in a FIFO_DEPTH-entry FIFO, and key_ready = !full.
- Full is signalled at FIFO_DEPTH entries, with pointer wrap-around at FIFO_DEPTH.
REQ-030 With KEYPAD_PLAYER_FIFO_EN undefined, there SHALL be a single holding register.
- key_ready = 1 only when the state is IDLE and no key is pending.
- The key pops on the next edge, so key_ready = 0 from the accept edge through the end of GAP.

Verification
REQ-031 The bench SHALL use HOLD_CYCLES = 4 and GAP_CYCLES = 3 for the scenarios below.
REQ-032 Single key: accept key_idx = 5 at edge N -> pb = 16'hFFDF for edges N+2..N+5, pb = 16'hFFFF for N+6..N+8, key_done pulses at N+9, keys_sent = 1.
REQ-033 Back-to-back (FIFO_EN): push 0, 13, 15 on consecutive cycles -> presses appear on pb bits 0, 13, 15 in order, each 4 cycles low with a 3-cycle gap and no IDLE cycle between, ending with keys_sent = 3.
REQ-034 Full (FIFO_EN, depth 8): 10 pushes with key_valid held high -> key_ready drops after occupancy reaches 8, exactly 9 keys are eventually pressed (1 in flight plus 8 queued), and the dropped 10th is never pressed.
REQ-035 Reset mid-press: key 15 pressed, rst = 1 at the 2nd press cycle -> pb = 16'hFFFF on that edge, no key_done, keys_sent = 0, queue empty.
REQ-036 Wrap: run 256 keys -> keys_sent = 0 with exactly 256 key_done pulses.
REQ-037 No FIFO: with KEYPAD_PLAYER_FIFO_EN undefined, accept 3 at edge N -> key_ready = 0 for edges N..N+8, 1 again at N+9, and a key_valid during N+1..N+8 is ignored.
